// File: rtl/set_job_arbiter.sv
// Round-robin front end that time-shares one SET circle-candidate engine among NREQ
// requesters; a watchdog turns a job the engine never finishes into a timeout response.
module set_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*24-1:0]   req_central,
  input  logic [NREQ*12-1:0]   req_radius,
  input  logic [NREQ*2-1:0]    req_mode,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [7:0]           res_candidate,
  output logic                 res_timeout,
  output logic [2:0]           res_id,
  output logic                 set_en,
  output logic [23:0]          set_central,
  output logic [11:0]          set_radius,
  output logic [1:0]           set_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [7:0]           set_candidate
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic [2:0]        r_ptr;
  logic [2:0]        r_owner;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic [7:0]        r_cand;
  logic              r_timeout;
  logic [2:0]        r_resId;
  logic [23:0]       r_central;
  logic [11:0]       r_radius;
  logic [1:0]        r_mode;
  logic [TW-1:0]     r_wd;

  logic              w_anyReq;
  logic [2:0]        w_pick;
  logic [23:0]       w_pickCentral;
  logic [11:0]       w_pickRadius;
  logic [1:0]        w_pickMode;
  logic              w_launch;
  logic [TW-1:0]     w_wdNext;
  logic              w_expired;
  logic [NREQ-1:0]   w_ownerHot;
  logic [NREQ-1:0]   w_pickHot;

  // First set request strictly after the pointer, wrapping modulo NREQ.
  function automatic logic [2:0] rrPick(input logic [NREQ-1:0] reqs, input logic [2:0] ptr);
    logic [2:0] sel;
    logic       hit;
    int         idx;
    sel = '0;
    hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && (((reqs >> idx) & NREQ'(1)) != '0)) begin
        hit = 1'b1;
        sel = idx[2:0];
      end
    end
    return sel;
  endfunction

  assign w_anyReq      = |req;
  assign w_pick        = rrPick(req, r_ptr);
  assign w_pickCentral = 24'(req_central >> (24 * int'(w_pick)));
  assign w_pickRadius  = 12'(req_radius  >> (12 * int'(w_pick)));
  assign w_pickMode    = 2'(req_mode     >> (2  * int'(w_pick)));
  assign w_pickHot     = NREQ'(1) << w_pick;
  assign w_ownerHot    = NREQ'(1) << r_owner;
  assign w_launch      = (r_state == S_LAUNCH) && !set_busy;
  assign w_wdNext      = r_wd + 1'b1;
  assign w_expired     = (w_wdNext == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (w_anyReq) w_nextState = S_LAUNCH;
      S_LAUNCH: if (!set_busy) w_nextState = S_WAIT;
      S_WAIT:   if (set_valid || w_expired) w_nextState = S_RESP;
      S_RESP:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Operands are only rewritten on a grant, so the engine sees them stable for the whole job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= 3'(NREQ - 1);
      r_owner   <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_cand    <= '0;
      r_timeout <= 1'b0;
      r_resId   <= '0;
      r_central <= '0;
      r_radius  <= '0;
      r_mode    <= '0;
      r_wd      <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_gnt     <= w_pickHot;
            r_central <= w_pickCentral;
            r_radius  <= w_pickRadius;
            r_mode    <= w_pickMode;
            r_ptr     <= w_pick;
            r_owner   <= w_pick;
          end
        end
        S_LAUNCH: begin
          if (!set_busy) r_wd <= '0;
        end
        S_WAIT: begin
          // A valid arriving on the expiry cycle still delivers the real result.
          if (set_valid) begin
            r_cand    <= set_candidate;
            r_timeout <= 1'b0;
            r_done    <= w_ownerHot;
            r_resId   <= r_owner;
          end else if (w_expired) begin
            r_cand    <= '0;
            r_timeout <= 1'b1;
            r_done    <= w_ownerHot;
            r_resId   <= r_owner;
          end else begin
            r_wd <= w_wdNext;
          end
        end
        S_RESP: begin
          r_timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The engine shares rst, so a reset mid-job drops the job on both sides.
  assign gnt           = r_gnt;
  assign done          = r_done;
  assign res_candidate = r_cand;
  assign res_timeout   = r_timeout;
  assign res_id        = r_resId;
  assign set_en        = w_launch;
  assign set_central   = r_central;
  assign set_radius    = r_radius;
  assign set_mode      = r_mode;

endmodule

// File: tb/tb_set_job_arbiter.sv
// Self-checking bench for set_job_arbiter: behavioural engine model, scoreboard of
// expected responses pushed on grant, vector table for arbitration order plus corner cases.
module tb_set_job_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*24-1:0]  req_central;
  logic [NREQ*12-1:0]  req_radius;
  logic [NREQ*2-1:0]   req_mode;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic [7:0]          res_candidate;
  logic                res_timeout;
  logic [2:0]          res_id;
  logic                set_en;
  logic [23:0]         set_central;
  logic [11:0]         set_radius;
  logic [1:0]          set_mode;
  logic                set_busy;
  logic                set_valid;
  logic [7:0]          set_candidate;

  logic [23:0] jobC [NREQ];
  logic [11:0] jobR [NREQ];
  logic [1:0]  jobM [NREQ];

  assign req_central = {jobC[3], jobC[2], jobC[1], jobC[0]};
  assign req_radius  = {jobR[3], jobR[2], jobR[1], jobR[0]};
  assign req_mode    = {jobM[3], jobM[2], jobM[1], jobM[0]};

  set_job_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(10)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_central(req_central), .req_radius(req_radius), .req_mode(req_mode),
    .gnt(gnt), .done(done), .res_candidate(res_candidate), .res_timeout(res_timeout),
    .res_id(res_id), .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
    .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int enCount    = 0;
  int gntCount   = 0;
  int doneCount  = 0;
  int enCyc      = 0;
  int validCyc   = 0;
  int doneCyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] candFn(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    return c[7:0] ^ c[15:8] ^ c[23:16] ^ r[7:0] ^ {r[11:8], 2'b00, m};
  endfunction

  // Behavioural engine: latches operands on set_en, answers after engLatency cycles.
  int          engLatency = 0;
  logic        engNever   = 1'b0;
  logic        strayValid = 1'b0;
  logic        engActive;
  logic        engValid;
  int          engCnt;
  logic [7:0]  engCand;
  logic [37:0] engCap;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      engActive <= 1'b0;
      engValid  <= 1'b0;
      engCnt    <= 0;
      engCand   <= '0;
      engCap    <= '0;
    end else begin
      engValid <= 1'b0;
      if (set_en) begin
        engActive <= 1'b1;
        engCnt    <= engLatency;
        engCap    <= {set_central, set_radius, set_mode};
        engCand   <= candFn(set_central, set_radius, set_mode);
      end else if (done != '0) begin
        engActive <= 1'b0;
      end else if (engActive && !engNever) begin
        if (engCnt == 0) begin
          engValid  <= 1'b1;
          engActive <= 1'b0;
        end else begin
          engCnt <= engCnt - 1;
        end
      end
    end
  end

  assign set_valid     = engValid | strayValid;
  assign set_candidate = strayValid ? 8'hAA : engCand;

  typedef struct {
    int         id;
    logic [7:0] cand;
    logic       to;
  } expT;
  expT expQ[$];

  typedef struct {
    logic [3:0] mask;
    int         expId;
    int         lat;
  } vecT;
  vecT vecs[9];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expire(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: no response within cycle budget", name);
  endtask

  task automatic waitGnt(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk); #1;
      if (gnt != '0) seen = 1'b1;
    end
    if (!seen) expire("gnt wait");
    #2;
  endtask

  task automatic waitDone(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk); #1;
      if (done != '0) seen = 1'b1;
    end
    if (!seen) expire("done wait");
    #2;
  endtask

  task automatic applyStimulus(input vecT v);
    engLatency = v.lat;
    req        = v.mask;
    waitGnt(20);
    checkOutput("vec gnt", 64'(gnt), 64'(4'b0001 << v.expId));
    waitDone(30);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput(name, 64'({gnt, done, set_en, res_candidate, res_timeout, res_id,
                           set_central, set_radius, set_mode}), 64'd0);
  endtask

  // Monitor: sampled mid-low-phase, after the driver has settled inputs on the falling edge.
  int  monId;
  expT monE;
  always @(negedge clk) begin
    #2;
    if (set_en) begin
      enCount++;
      enCyc = cyc;
    end
    if (set_valid) validCyc = cyc;
    if (engActive) checkOutput("operand hold", 64'({set_central, set_radius, set_mode}), 64'(engCap));
    if (gnt != '0) begin
      gntCount++;
      checkOutput("gnt onehot", 64'($onehot(gnt)), 64'd1);
      monId = 0;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) monId = i;
      checkOutput("gnt operands", 64'({set_central, set_radius, set_mode}),
                  64'({jobC[monId], jobR[monId], jobM[monId]}));
      monE.id   = monId;
      monE.to   = engNever;
      monE.cand = engNever ? 8'h00 : candFn(jobC[monId], jobR[monId], jobM[monId]);
      expQ.push_back(monE);
    end
    if (done != '0) begin
      doneCount++;
      doneCyc = cyc;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected done: got 0x%0h, expected none", done);
      end else begin
        monE = expQ.pop_front();
        checkOutput("done onehot", 64'(done), 64'(4'b0001 << monE.id));
        checkOutput("res_id", 64'(res_id), 64'(monE.id));
        checkOutput("res_candidate", 64'(res_candidate), 64'(monE.cand));
        checkOutput("res_timeout", 64'(res_timeout), 64'(monE.to));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  int e0, d0, g0;

  initial begin
    vecs[0] = '{4'b1111, 0, 0};
    vecs[1] = '{4'b1111, 1, 0};
    vecs[2] = '{4'b1111, 2, 0};
    vecs[3] = '{4'b1111, 3, 0};
    vecs[4] = '{4'b1111, 0, 1};
    vecs[5] = '{4'b1111, 1, 2};
    vecs[6] = '{4'b0100, 2, 0};
    vecs[7] = '{4'b0101, 0, 0};
    vecs[8] = '{4'b0101, 2, 1};

    jobC[0] = 24'h345626; jobR[0] = 12'h323; jobM[0] = 2'b00;
    jobC[1] = 24'hA1B2C3; jobR[1] = 12'h5E7; jobM[1] = 2'b01;
    jobC[2] = 24'h0F1E2D; jobR[2] = 12'h9AB; jobM[2] = 2'b10;
    jobC[3] = 24'h778899; jobR[3] = 12'h1C4; jobM[3] = 2'b11;

    rst = 1'b0; req = '0; set_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkAllZero("reset outputs");
    @(negedge clk); rst = 1'b1;

    // Single job from requester 0
    e0 = enCount;
    engLatency = 3;
    @(negedge clk); req = 4'b0001;
    waitGnt(20);
    checkOutput("t1 gnt", 64'(gnt), 64'h1);
    req = '0;
    @(negedge clk); #1;
    checkOutput("t1 gnt one cycle", 64'(gnt), 64'h0);
    waitDone(30);
    checkOutput("t1 done after valid", 64'(doneCyc), 64'(validCyc + 1));
    checkOutput("t1 set_en pulses", 64'(enCount - e0), 64'd1);
    @(negedge clk); #1;
    checkOutput("t1 done one cycle", 64'(done), 64'h0);

    // Fresh pointer so requester 0 leads the round-robin sequence
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int v = 0; v < 9; v++) applyStimulus(vecs[v]);
    @(negedge clk); req = '0;

    // Engine busy during launch
    e0 = enCount;
    engLatency = 1;
    set_busy = 1'b1;
    req = 4'b0100;
    waitGnt(20);
    req = '0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checkOutput("t4 set_en held while busy", 64'(set_en), 64'd0);
    end
    @(negedge clk); set_busy = 1'b0; #1;
    checkOutput("t4 set_en on busy release", 64'(set_en), 64'd1);
    @(negedge clk); #1;
    checkOutput("t4 set_en single", 64'(set_en), 64'd0);
    waitDone(30);
    checkOutput("t4 set_en pulses", 64'(enCount - e0), 64'd1);

    // Engine never answers: watchdog abort, then a normal job
    engNever = 1'b1;
    @(negedge clk); req = 4'b0010;
    waitGnt(20);
    req = '0;
    waitDone(40);
    // TIMEOUT silent WAIT cycles after the launch cycle, then done in RESP
    checkOutput("t5 timeout latency", 64'(doneCyc - enCyc), 64'(TIMEOUT + 1));
    @(negedge clk); #1;
    checkOutput("t5 res_timeout clears", 64'(res_timeout), 64'd0);
    engNever = 1'b0;
    engLatency = 2;
    req = 4'b0010;
    waitGnt(20);
    req = '0;
    waitDone(30);

    // A request dropped before it is granted is not served
    engLatency = 8;
    @(negedge clk); req = 4'b0001;
    waitGnt(20);
    req = '0;
    @(negedge clk); req = 4'b1000;
    repeat (2) @(negedge clk);
    req = '0;
    waitDone(30);
    g0 = gntCount;
    repeat (4) @(negedge clk);
    #3 checkOutput("dropped req not granted", 64'(gntCount), 64'(g0));

    // Reset while the engine is working
    engNever = 1'b1;
    @(negedge clk); req = 4'b0010;
    waitGnt(20);
    req = '0;
    repeat (5) @(negedge clk);
    d0 = doneCount;
    rst = 1'b0;
    #1 checkAllZero("t6 reset mid-job outputs");
    expQ.delete();
    engNever = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3 checkOutput("t6 no done after reset", 64'(doneCount), 64'(d0));

    // Stray valid while idle
    e0 = enCount; g0 = gntCount;
    @(negedge clk); strayValid = 1'b1;
    @(negedge clk); strayValid = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    checkOutput("t6 stray valid no done", 64'(doneCount), 64'(d0));
    checkOutput("t6 stray valid no launch", 64'(enCount - e0), 64'd0);
    checkOutput("t6 stray valid no gnt", 64'(gntCount - g0), 64'd0);
    engLatency = 2;
    @(negedge clk); req = 4'b0010;
    waitGnt(20);
    checkOutput("t6 gnt after stray", 64'(gnt), 64'h2);
    req = '0;
    waitDone(30);
    repeat (3) @(negedge clk);
    #3 checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
